// File: rtl/adc_uart_pkg.sv
// adc_uart_pkg
//   Shared constants and types for the ADC-to-UART framer and any future
//   receiver-side frame checker.
//   FRAME_LEN         : bytes per frame (sync, ch1 hi/lo, ch2 hi/lo, checksum)
//   SYNC_BYTE_DEFAULT : default leading sync byte
//   IDX_W             : width of the byte index within a frame
//   state_t           : framer FSM state encoding (ST_IDLE, ST_SEND)
package adc_uart_pkg;

    localparam int          FRAME_LEN         = 6;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int          IDX_W             = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/frame_checksum.sv
// frame_checksum
//   Combinational XOR checksum over the four payload bytes of a frame.
//   ch1 : channel 1 sample (16 bits)
//   ch2 : channel 2 sample (16 bits)
//   chk : ch1[15:8] ^ ch1[7:0] ^ ch2[15:8] ^ ch2[7:0]
module frame_checksum (
    input  logic [15:0] ch1,
    input  logic [15:0] ch2,
    output logic [7:0]  chk
);

    assign chk = ch1[15:8] ^ ch1[7:0] ^ ch2[15:8] ^ ch2[7:0];

endmodule

// File: rtl/adc_uart_framer.sv
// adc_uart_framer
//   Decimates ADC ch1/ch2 sample pairs, packs one pair into a 6-byte frame
//   (sync, ch1 hi, ch1 lo, ch2 hi, ch2 lo, checksum) and streams it over an
//   AXI-stream style handshake into uart_tx.
//   i_clock/i_reset     : clock, synchronous active-high reset
//   i_enable            : capture enable; low holds the decimation counter at 0
//   i_sample_valid      : one-cycle strobe, i_ch1/i_ch2 carry a new pair
//   o_tdata/o_tvalid    : byte stream toward uart_tx
//   i_tready            : uart_tx ready
//   o_busy              : frame in flight
//   o_frame_done        : one-cycle pulse on the last-byte handshake
//   o_overrun           : saturating count of due captures dropped while busy
module adc_uart_framer
    import adc_uart_pkg::*;
#(
    parameter int         DECIM     = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         OVR_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_sample_valid,
    input  logic [15:0]          i_ch1,
    input  logic [15:0]          i_ch2,
    output logic [7:0]           o_tdata,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [OVR_WIDTH-1:0] o_overrun
);

    localparam int               CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] decim_cnt;
    logic             due;
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [15:0]      ch1_q;
    logic [15:0]      ch2_q;
    logic [7:0]       chk_q;
    logic [7:0]       chk_in;
    logic [7:0]       next_byte;

    // A capture is due on the valid sample that completes a decimation period.
    assign due = i_enable & i_sample_valid & (decim_cnt == CNT_LAST);

    // Decimation counter runs independently of the FSM so the capture cadence
    // stays fixed even when frames are being dropped.
    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable) begin
            decim_cnt <= '0;
        end else if (i_sample_valid) begin
            decim_cnt <= due ? '0 : decim_cnt + 1'b1;
        end
    end

    frame_checksum u_checksum (
        .ch1 (i_ch1),
        .ch2 (i_ch2),
        .chk (chk_in)
    );

    // Byte presented after the current one is accepted; o_tdata is loaded from
    // here so the output stays registered.
    assign idx_nxt = idx + 1'b1;

    always_comb begin
        next_byte = SYNC_BYTE;
        case (idx_nxt)
            3'd1:    next_byte = ch1_q[15:8];
            3'd2:    next_byte = ch1_q[7:0];
            3'd3:    next_byte = ch2_q[15:8];
            3'd4:    next_byte = ch2_q[7:0];
            3'd5:    next_byte = chk_q;
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            ch1_q        <= '0;
            ch2_q        <= '0;
            chk_q        <= '0;
            o_tvalid     <= 1'b0;
            o_tdata      <= 8'h00;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= '0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (due) begin
                        ch1_q    <= i_ch1;
                        ch2_q    <= i_ch2;
                        chk_q    <= chk_in;
                        idx      <= '0;
                        state    <= ST_SEND;
                        o_tvalid <= 1'b1;
                        o_tdata  <= SYNC_BYTE;
                        o_busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    // Still SEND on the last-byte handshake, so a capture due
                    // in that same cycle is dropped too.
                    if (due && (o_overrun != '1)) begin
                        o_overrun <= o_overrun + 1'b1;
                    end
                    // o_tvalid is always 1 in SEND, so i_tready alone marks
                    // the handshake.
                    if (i_tready) begin
                        if (idx == IDX_LAST) begin
                            state        <= ST_IDLE;
                            idx          <= '0;
                            o_tvalid     <= 1'b0;
                            o_tdata      <= 8'h00;
                            o_busy       <= 1'b0;
                            o_frame_done <= 1'b1;
                        end else begin
                            idx     <= idx_nxt;
                            o_tdata <= next_byte;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
// tb_adc_uart_framer
//   Two framer instances (DECIM=4/OVR_WIDTH=8 and DECIM=1/OVR_WIDTH=2) share
//   one randomized stimulus stream. Each has a frame-level reference model that
//   queues expected bytes at capture time and a monitor that pops them on
//   handshakes and checks the status outputs.
module tb_adc_uart_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sv;
    logic        tready;
    logic [15:0] ch1;
    logic [15:0] ch2;
    logic        chk_on    = 1'b0;
    logic        drain_req = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int DEC  = (g == 0) ? 4 : 1;
        localparam int OW   = (g == 0) ? 8 : 2;
        localparam int OMAX = (1 << OW) - 1;

        logic [7:0]    tdata;
        logic          tvalid;
        logic          busy;
        logic          done;
        logic [OW-1:0] ovr;

        adc_uart_framer #(.DECIM(DEC), .SYNC_BYTE(8'hA5), .OVR_WIDTH(OW)) dut (
            .i_clock        (clk),
            .i_reset        (rst),
            .i_enable       (en),
            .i_sample_valid (sv),
            .i_ch1          (ch1),
            .i_ch2          (ch2),
            .o_tdata        (tdata),
            .o_tvalid       (tvalid),
            .i_tready       (tready),
            .o_busy         (busy),
            .o_frame_done   (done),
            .o_overrun      (ovr)
        );

        // Reference model: valid-sample count modulo DEC decides captures; a
        // frame in flight is just a number of bytes still owed to the UART.
        logic [7:0] exp_q[$];
        int         m_cnt  = 0;
        int         m_pend = 0;
        int         m_ovr  = 0;
        bit         m_done = 0;
        bit         drained = 0;

        initial forever begin
            bit due;
            bit was_busy;
            @(posedge clk);
            m_done = 0;
            if (rst) begin
                exp_q.delete();
                m_cnt  = 0;
                m_pend = 0;
                m_ovr  = 0;
            end else begin
                was_busy = (m_pend != 0);
                due = 0;
                if (!en) m_cnt = 0;
                else if (sv) begin
                    m_cnt = (m_cnt + 1) % DEC;
                    due = (m_cnt == 0);
                end
                if (was_busy && tready) begin
                    m_pend--;
                    m_done = (m_pend == 0);
                end
                if (due) begin
                    if (was_busy) begin
                        m_ovr = (m_ovr < OMAX) ? m_ovr + 1 : OMAX;
                    end else begin
                        exp_q.push_back(8'hA5);
                        exp_q.push_back(ch1[15:8]);
                        exp_q.push_back(ch1[7:0]);
                        exp_q.push_back(ch2[15:8]);
                        exp_q.push_back(ch2[7:0]);
                        exp_q.push_back(ch1[15:8] ^ ch1[7:0] ^ ch2[15:8] ^ ch2[7:0]);
                        m_pend = 6;
                    end
                end
            end
        end

        // Monitor: sample mid-cycle; a byte shown with tready high is consumed
        // at the coming edge.
        initial forever begin
            @(negedge clk);
            if (chk_on) begin
                chk(g, "tvalid", 32'(tvalid), 32'(m_pend != 0));
                chk(g, "busy", 32'(busy), 32'(m_pend != 0));
                chk(g, "frame_done", 32'(done), 32'(m_done));
                chk(g, "overrun", 32'(ovr), 32'(m_ovr));
                if (tvalid) begin
                    if (exp_q.size() == 0) begin
                        chk(g, "unexpected_byte", 32'(tdata), 32'hFFFF_FFFF);
                    end else begin
                        chk(g, "tdata", 32'(tdata), 32'(exp_q[0]));
                        if (tready) void'(exp_q.pop_front());
                    end
                end
                if (drain_req && !drained) begin
                    chk(g, "drained", 32'(exp_q.size()), 32'd0);
                    drained = 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four back-to-back valids after clearing the decimation counter; the
    // DECIM=4 instance captures on the fourth with the given data.
    task automatic burst4(input logic [15:0] a, input logic [15:0] b);
        en = 1'b0;
        step(1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sv  = 1'b1;
            ch1 = (i == 3) ? a : 16'($urandom);
            ch2 = (i == 3) ? b : 16'($urandom);
            step(1);
        end
        sv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sv = 1'b0; tready = 1'b1; ch1 = '0; ch2 = '0;
        step(2);
        chk_on = 1'b1;
        rst = 1'b0;
        step(1);

        // Directed frame, no back-pressure.
        burst4(16'h1234, 16'hABCD);
        step(12);

        // Random traffic with back-pressure bursts and an enable-off window.
        for (int i = 0; i < 500; i++) begin
            sv     = ($urandom_range(0, 2) == 0);
            ch1    = 16'($urandom);
            ch2    = 16'($urandom);
            tready = ($urandom_range(0, 3) != 0) && ((i % 37) >= 5);
            en     = !(i >= 250 && i < 300);
            step(1);
        end
        sv = 1'b0; tready = 1'b1; en = 1'b1;
        step(20);

        // Reset while the DECIM=4 instance is on byte 3.
        burst4(16'hC0DE, 16'h5A3C);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        burst4(16'h0F0F, 16'hFFFF);
        step(12);

        // Valid every cycle: DECIM=1 drops 6 per frame and saturates at 3.
        sv = 1'b1; tready = 1'b1; en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ch1 = 16'($urandom);
            ch2 = 16'($urandom);
            step(1);
        end
        sv = 1'b0;
        step(20);

        drain_req = 1'b1;
        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
